// File: rtl/fdc_pkg.sv
// Shared types for the floppy sector engine.
// State encoding, sector geometry and CHS-to-LBA mapping.
package fdc_pkg;

    localparam int SECTOR_BYTES = 512;

    typedef logic [8:0] sec_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_REQ,
        ST_XFER,
        ST_FIN
    } state_e;

    // Image blocks are laid out track-major, side, then sector.
    function automatic logic [31:0] chs_to_lba(
        input logic [6:0] track,
        input logic       side,
        input logic [3:0] sector,
        input logic [3:0] spt,
        input logic       ds
    );
        logic [31:0] cyl_head;
        cyl_head = {25'd0, track} * (ds ? 32'd2 : 32'd1) + {31'd0, side};
        return cyl_head * {28'd0, spt} + {28'd0, sector} - 32'd1;
    endfunction

endpackage

// File: rtl/fdc_sector_ram.sv
// 512x8 true dual-port sector buffer.
// Port A faces the controller, port B the SD host.
module fdc_sector_ram
    import fdc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  sec_addr_t  a_addr_i,
    input  logic       a_we_i,
    input  logic [7:0] a_wdata_i,
    output logic [7:0] a_rdata_o,
    input  sec_addr_t  b_addr_i,
    input  logic       b_we_i,
    input  logic [7:0] b_wdata_i,
    output logic [7:0] b_rdata_o
);

    logic [7:0] mem_q [SECTOR_BYTES];
    logic [7:0] a_rdata_q;
    logic [7:0] b_rdata_q;

    // Storage; the engine never enables both write ports at once.
    always_ff @(posedge clk) begin
        if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
        if (b_we_i) mem_q[b_addr_i] <= b_wdata_i;
    end

    // Registered read ports, cleared on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata_q <= 8'h00;
            b_rdata_q <= 8'h00;
        end else begin
            a_rdata_q <= mem_q[a_addr_i];
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/wd_sector_engine.sv
// Sector engine between the WD2793 controller and the SD image.
// Maps CHS to LBA, runs the SD block handshake, buffers one sector.
module wd_sector_engine
    import fdc_pkg::*;
#(
    parameter int TIMEOUT_W = 22
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [6:0]  track,
    input  logic        side,
    input  logic [3:0]  sector,
    input  logic [3:0]  spt,
    input  logic        double_sided,
    input  logic        img_mounted,
    input  logic [31:0] img_lba_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [8:0]  buf_addr,
    input  logic        buf_wr,
    input  logic [7:0]  buf_wdata,
    output logic [7:0]  buf_rdata,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din
);

    localparam logic [TIMEOUT_W-1:0] WD_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    state_e                state_q;
    logic                  dir_wr_q;
    logic [6:0]            track_q;
    logic                  side_q;
    logic [3:0]            sector_q;
    logic [3:0]            spt_q;
    logic                  ds_q;
    logic [TIMEOUT_W-1:0]  wd_q;
    logic [31:0]           sd_lba_q;
    logic                  sd_rd_q;
    logic                  sd_wr_q;
    logic                  done_q;
    logic                  error_q;

    logic [31:0] lba_d;
    logic        geom_err_d;
    logic        xfer_en;
    logic        a_we;
    logic        b_we;

    assign lba_d = chs_to_lba(track_q, side_q, sector_q, spt_q, ds_q);

    assign geom_err_d = !img_mounted
                     || (sector_q == 4'd0)
                     || (sector_q > spt_q)
                     || (side_q && !ds_q)
                     || (lba_d >= img_lba_count);

    // Host data may arrive as soon as ack rises, before XFER is entered.
    assign xfer_en = sd_ack && ((state_q == ST_REQ) || (state_q == ST_XFER));
    assign b_we    = xfer_en && !dir_wr_q && sd_buff_wr;
    assign a_we    = buf_wr && (state_q == ST_IDLE);

    // Request sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            dir_wr_q <= 1'b0;
            track_q  <= 7'd0;
            side_q   <= 1'b0;
            sector_q <= 4'd0;
            spt_q    <= 4'd0;
            ds_q     <= 1'b0;
            wd_q     <= '0;
            sd_lba_q <= 32'd0;
            sd_rd_q  <= 1'b0;
            sd_wr_q  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    wd_q <= '0;
                    if (req_read || req_write) begin
                        dir_wr_q <= !req_read;
                        track_q  <= track;
                        side_q   <= side;
                        sector_q <= sector;
                        spt_q    <= spt;
                        ds_q     <= double_sided;
                        state_q  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (geom_err_d) begin
                        error_q <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        sd_lba_q <= lba_d;
                        sd_rd_q  <= !dir_wr_q;
                        sd_wr_q  <= dir_wr_q;
                        wd_q     <= '0;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sd_ack) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        state_q <= ST_XFER;
                    end else if (&wd_q) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        wd_q <= wd_q + WD_ONE;
                    end
                end
                ST_XFER: begin
                    if (!sd_ack) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    fdc_sector_ram u_ram (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_addr_i  (buf_addr),
        .a_we_i    (a_we),
        .a_wdata_i (buf_wdata),
        .a_rdata_o (buf_rdata),
        .b_addr_i  (sd_buff_addr),
        .b_we_i    (b_we),
        .b_wdata_i (sd_buff_dout),
        .b_rdata_o (sd_buff_din)
    );

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign error  = error_q;
    assign sd_lba = sd_lba_q;
    assign sd_rd  = sd_rd_q;
    assign sd_wr  = sd_wr_q;

endmodule

// File: tb/tb_wd_sector_engine.sv
// Randomized bench for wd_sector_engine.
// Reference model: CHS geometry arithmetic plus a byte-array sector image.
module tb_wd_sector_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_read, req_write;
    logic [6:0]  track;
    logic        side;
    logic [3:0]  sector, spt;
    logic        double_sided, img_mounted;
    logic [31:0] img_lba_count;
    logic        busy, done, error;
    logic [8:0]  buf_addr;
    logic        buf_wr;
    logic [7:0]  buf_wdata, buf_rdata;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    int n_run  = 0;
    int n_fail = 0;
    logic [7:0] ref_mem [512];

    always #5 clk = ~clk;

    wd_sector_engine #(.TIMEOUT_W(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_read      (req_read),
        .req_write     (req_write),
        .track         (track),
        .side          (side),
        .sector        (sector),
        .spt           (spt),
        .double_sided  (double_sided),
        .img_mounted   (img_mounted),
        .img_lba_count (img_lba_count),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .buf_addr      (buf_addr),
        .buf_wr        (buf_wr),
        .buf_wdata     (buf_wdata),
        .buf_rdata     (buf_rdata),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .sd_buff_addr  (sd_buff_addr),
        .sd_buff_dout  (sd_buff_dout),
        .sd_buff_wr    (sd_buff_wr),
        .sd_buff_din   (sd_buff_din)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input bit rnd, input logic [7:0] val);
        for (int a = 0; a < 512; a++) begin
            buf_addr  = 9'(a);
            buf_wdata = rnd ? 8'($urandom) : val;
            buf_wr    = 1'b1;
            tick();
            ref_mem[a] = buf_wdata;
        end
        buf_wr = 1'b0;
    endtask

    task automatic readback(input int n);
        int a;
        for (int i = 0; i <= n; i++) begin
            a = (i == n) ? 511 : int'($urandom_range(0, 511));
            buf_addr = 9'(a);
            tick();
            check("buf_rdata", {24'd0, buf_rdata}, {24'd0, ref_mem[a]});
        end
    endtask

    task automatic set_geom(input int trk, input int sd, input int sec,
                            input int sp, input int ds, input int mnt,
                            input logic [31:0] cnt);
        track         = 7'(trk);
        side          = sd[0];
        sector        = 4'(sec);
        spt           = 4'(sp);
        double_sided  = ds[0];
        img_mounted   = mnt[0];
        img_lba_count = cnt;
    endtask

    task automatic run_op(input bit wr, input int trk, input int sd,
                          input int sec, input int sp, input int ds,
                          input int mnt, input logic [31:0] cnt,
                          input int ack_dly, input bit addr_pat);
        longint lba;
        bit     err;
        int     bad;
        logic [7:0] v;
        lba = longint'((trk * (ds != 0 ? 2 : 1) + sd) * sp + sec - 1);
        err = (mnt == 0) || (sec == 0) || (sec > sp) ||
              (sd != 0 && ds == 0) || (lba >= longint'(cnt));
        set_geom(trk, sd, sec, sp, ds, mnt, cnt);
        if (wr) req_write = 1'b1;
        else    req_read  = 1'b1;
        tick();
        req_read  = 1'b0;
        req_write = 1'b0;
        check("busy_rise", {31'd0, busy}, 32'd1);
        if (err) begin
            tick();
            check("err_pulse", {30'd0, error, done}, 32'h2);
            check("err_noreq", {30'd0, sd_rd, sd_wr}, 32'd0);
            tick();
            check("err_end", {30'd0, busy, error}, 32'd0);
            return;
        end
        tick();
        check("req_lvl", {30'd0, sd_rd, sd_wr}, wr ? 32'd1 : 32'd2);
        check("sd_lba", sd_lba, 32'(lba));
        for (int i = 0; i < ack_dly; i++) begin
            buf_addr  = 9'($urandom);
            buf_wdata = 8'($urandom);
            buf_wr    = 1'b1;
            tick();
            check("req_hold", {30'd0, sd_rd, sd_wr}, wr ? 32'd1 : 32'd2);
        end
        buf_wr = 1'b0;
        sd_ack = 1'b1;
        tick();
        check("req_drop", {30'd0, sd_rd, sd_wr}, 32'd0);
        bad = 0;
        for (int a = 0; a < 512; a++) begin
            sd_buff_addr = 9'(a);
            if (!wr) begin
                v = addr_pat ? 8'(a) : 8'($urandom);
                sd_buff_dout = v;
                sd_buff_wr   = 1'b1;
                tick();
                ref_mem[a] = v;
            end else begin
                tick();
                if (sd_buff_din !== ref_mem[a]) bad++;
            end
        end
        if (wr) check("xfer_din", 32'(bad), 32'd0);
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        tick();
        check("done_pulse", {29'd0, busy, done, error}, 32'h6);
        tick();
        check("done_end", {29'd0, busy, done, error}, 32'd0);
        readback(3);
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0;
        req_read = 1'b0;  req_write = 1'b0;
        set_geom(0, 0, 1, 9, 1, 1, 32'd1440);
        buf_addr = '0;  buf_wr = 1'b0;  buf_wdata = '0;
        sd_ack = 1'b0;  sd_buff_addr = '0;
        sd_buff_dout = '0;  sd_buff_wr = 1'b0;
        tick(); tick();
        check("rst_ctl", {28'd0, busy, done, error, sd_rd}, 32'd0);
        check("rst_wr", {31'd0, sd_wr}, 32'd0);
        check("rst_lba", sd_lba, 32'd0);
        check("rst_data", {16'd0, buf_rdata, sd_buff_din}, 32'd0);
        reset_n = 1'b1;
        tick();
        fill(1'b1, 8'h00);

        run_op(0, 0, 0, 1, 9, 1, 1, 32'd1440, 2, 1'b1);
        buf_addr = 9'h1FF;
        tick();
        check("rd_1ff", {24'd0, buf_rdata}, 32'hFF);
        run_op(0, 79, 1, 9, 9, 1, 1, 32'd1440, 1, 1'b0);
        run_op(0, 79, 1, 10, 9, 1, 1, 32'd1440, 0, 1'b0);

        fill(1'b0, 8'hA5);
        run_op(1, 2, 0, 3, 9, 1, 1, 32'd1440, 3, 1'b0);
        run_op(0, 5, 1, 2, 9, 0, 1, 32'd1440, 0, 1'b0);
        run_op(0, 5, 0, 2, 9, 1, 0, 32'd1440, 0, 1'b0);

        set_geom(1, 0, 1, 9, 1, 1, 32'd1440);
        req_read = 1'b1;
        tick();
        req_read = 1'b0;
        tick();
        check("to_req", {31'd0, sd_rd}, 32'd1);
        cyc = 0;
        while (!error && cyc < 40) begin
            tick();
            cyc++;
        end
        check("to_cycles", 32'(cyc), 32'd16);
        check("to_drop", {30'd0, sd_rd, error}, 32'd1);
        tick();
        check("to_idle", {31'd0, busy}, 32'd0);

        set_geom(3, 1, 4, 9, 1, 1, 32'd1440);
        req_read = 1'b1;
        tick();
        req_read = 1'b0;
        tick();
        sd_ack = 1'b1;
        tick();
        for (int a = 0; a < 100; a++) begin
            sd_buff_addr = 9'(a);
            sd_buff_dout = 8'($urandom);
            sd_buff_wr   = 1'b1;
            tick();
            ref_mem[a] = sd_buff_dout;
        end
        reset_n = 1'b0;
        #1;
        check("rst_mid", {28'd0, busy, sd_rd, sd_wr, done}, 32'd0);
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        tick(); tick();
        check("rst_hold", {30'd0, busy, error}, 32'd0);
        reset_n = 1'b1;
        tick();
        run_op(0, 3, 1, 4, 9, 1, 1, 32'd1440, 1, 1'b0);

        for (int n = 0; n < 14; n++) begin
            int sp, sec, cntsel;
            logic [31:0] cnt;
            sp     = ($urandom_range(0, 1) != 0) ? 9 : 8;
            sec    = int'($urandom_range(0, 15)) == 0 ? 0 :
                     int'($urandom_range(1, 10));
            cntsel = int'($urandom_range(0, 3));
            cnt    = (cntsel == 0) ? 32'($urandom_range(0, 300)) : 32'd1440;
            if ($urandom_range(0, 2) == 0) fill(1'b1, 8'h00);
            run_op(1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 83)),
                   int'($urandom_range(0, 1)),
                   sec, sp,
                   int'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 0 : 1,
                   cnt,
                   int'($urandom_range(0, 6)),
                   1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/wd_sector_engine.md
# wd_sector_engine

Disk-image sector engine sitting directly upstream of the WD2793 floppy controller: converts a controller track/side/sector request into an SD-image LBA, runs the MiSTer SD block handshake, and holds the 512-byte sector in a local buffer the controller accesses bytewise. Handles both reads (image to buffer) and writes (buffer to image), and reports completion or error back to the controller.

## Interface
- TIMEOUT_W, 22: width of the SD-acknowledge watchdog; timeout fires after 2^TIMEOUT_W cycles without sd_ack.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_read / req_write  in  1  one-cycle start pulses from the controller
- track  in  7  physical track 0..127
- side  in  1  head select
- sector  in  4  1-based sector number
- spt  in  4  sectors per track of the mounted image (8 or 9)
- double_sided  in  1  image has two sides
- img_mounted  in  1  image present
- img_lba_count  in  32  image size in 512-byte blocks
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, successful completion
- error  out  1  one-cycle pulse, failed operation (coincides with end of busy)
- buf_addr  in  9  controller byte address
- buf_wr  in  1  controller byte write strobe
- buf_wdata  in  8  controller write data
- buf_rdata  out  8  controller read data, 1-cycle latency
- sd_lba  out  32  block address to SD host
- sd_rd / sd_wr  out  1  SD block request levels
- sd_ack  in  1  SD host acknowledge (high for the whole transfer)
- sd_buff_addr  in  9  SD host byte address
- sd_buff_dout  in  8  data from SD host
- sd_buff_wr  in  1  SD host write strobe
- sd_buff_din  out  8  data to SD host, 1-cycle latency from sd_buff_addr

## Operation
- States: IDLE, CALC, REQ, XFER, FIN.
- IDLE: on req_read or req_write latch direction and geometry, go CALC; both pulses in the same cycle -> read wins. Requests outside IDLE ignored.
- CALC (1 cycle): lba = (track * (double_sided ? 2 : 1) + side) * spt + (sector - 1), computed 32-bit unsigned. Error if !img_mounted, sector == 0, sector > spt, side && !double_sided, or lba >= img_lba_count -> FIN with error; else load sd_lba, go REQ.
- REQ: assert sd_rd (read) or sd_wr (write); hold until sd_ack seen high, then drop request, go XFER. Watchdog counts in REQ; on overflow -> FIN with error.
- XFER: while sd_ack high, read path writes sd_buff_dout into buffer at sd_buff_addr on sd_buff_wr; write path drives sd_buff_din from buffer. Falling edge of sd_ack -> FIN ok.
- FIN (1 cycle): pulse done or error, return IDLE.
- busy = state != IDLE.
- Controller buffer writes honoured only in IDLE; ignored while busy. Controller reads always honoured (contents undefined during a read transfer).

## Timing
- Reset values: busy 0, done 0, error 0, sd_rd 0, sd_wr 0, sd_lba 0, buf_rdata 0, sd_buff_din 0; state IDLE, watchdog 0. Buffer RAM not cleared.
- Request pulse at cycle N -> busy high at N+1, sd_rd/sd_wr high at N+2 (valid case), error pulse at N+2 (geometry error).
- sd_rd/sd_wr fall the cycle after sd_ack is sampled high.
- done/error pulse one cycle after sd_ack falling edge sampled; busy low the same cycle as the pulse ends.
- Reset mid-transfer: immediate return to IDLE, requests dropped, no done/error pulse.

## Structure
- Shared package fdc_pkg: state enum, SECTOR_BYTES = 512, sector-address typedef (9-bit).
- Sub-module fdc_sector_ram: 512x8 true dual-port RAM, registered reads on both ports; port A controller, port B SD host.

## Test plan
- Read track 0 side 0 sector 1, spt 9, double-sided, lba_count 1440 -> sd_lba 0, sd_rd until ack; 512 bytes (value = addr[7:0]) loaded; done pulse; buf_addr 0x1FF reads 0xFF.
- Read track 79 side 1 sector 9 -> sd_lba 1439, done; same with sector 10 -> error pulse, sd_rd never asserted.
- Write: controller fills buffer with 0xA5, req_write track 2 side 0 sector 3 (spt 9, double-sided) -> sd_lba 38, sd_wr asserted, sd_buff_din = 0xA5 at every address, done.
- side 1 on single-sided image, or img_mounted 0 -> error within 2 cycles, busy pulse only 2 cycles.
- No sd_ack with TIMEOUT_W = 4 -> sd_rd dropped and error after 16 cycles in REQ.
- reset_n low during XFER -> busy, sd_rd/sd_wr 0 immediately; new req_read afterward completes normally.
